// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out framer.
// Holds the FSM state encoding, legal word-width limits and the parity helper.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // Even parity: the bit that makes the total count of ones even.
    // Narrower words are zero-extended by the caller.
    function automatic logic parity_of(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial-side outputs of the framer, bundled as one port.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, frame_start, frame_done, busy
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag.
// Updates on the falling edge so it stays in step with the serial stages.
module bit_counter #(
    parameter int           W    = 2,
    parameter logic [W-1:0] LAST = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Clear wins over enable so a new frame always starts counting at zero.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer: accepts a word on a valid/ready handshake and
// emits it one bit per falling edge, optionally followed by an even-parity bit.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_serializer_if.slave     bus
);

    localparam int CNT_W = (WIDTH > MIN_WIDTH) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic               par_bit;
    logic               par_next;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               last_cycle;
    logic               hs;
    logic               advance;
    logic               sout_n;
    logic               valid_n;
    logic               start_n;
    logic               done_n;
    logic               sout_q;
    logic               valid_q;
    logic               start_q;
    logic               done_q;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    bit_counter #(
        .W    (CNT_W),
        .LAST (CNT_W'(WIDTH - 1))
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (hs),
        .en    (advance),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // Ready also rises on the final bit of a frame so words stream without a gap.
    assign last_cycle    = (state == SHIFT && cnt_tc && !PARITY_EN) || (state == PARITY);
    assign bus.din_ready = !rst && ((state == IDLE) || last_cycle);
    assign hs            = bus.din_valid && bus.din_ready;
    assign advance       = (state == SHIFT) && !cnt_tc;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hs) next_state = SHIFT;
            end
            SHIFT: begin
                if (!cnt_tc)        next_state = SHIFT;
                else if (PARITY_EN) next_state = PARITY;
                else if (hs)        next_state = SHIFT;
                else                next_state = IDLE;
            end
            PARITY: begin
                next_state = hs ? SHIFT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered serial outputs; a load always wins because
    // it can only fire in IDLE or on the last bit of the current frame.
    always_comb begin
        shreg_next = shreg;
        par_next   = par_bit;
        sout_n     = 1'b0;
        valid_n    = 1'b0;
        start_n    = 1'b0;
        done_n     = 1'b0;
        if (hs) begin
            shreg_next = bus.din;
            par_next   = parity_of(MAX_WIDTH'(bus.din));
            sout_n     = head(bus.din);
            valid_n    = 1'b1;
            start_n    = 1'b1;
        end else if (advance) begin
            shreg_next = shifted(shreg);
            sout_n     = head(shifted(shreg));
            valid_n    = 1'b1;
            done_n     = !PARITY_EN && (cnt == CNT_W'(WIDTH - 2));
        end else if (state == SHIFT && PARITY_EN) begin
            sout_n     = par_bit;
            valid_n    = 1'b1;
            done_n     = 1'b1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            par_bit <= 1'b0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg   <= shreg_next;
            par_bit <= par_next;
            sout_q  <= sout_n;
            valid_q <= valid_n;
            start_q <= start_n;
            done_q  <= done_n;
        end
    end

    assign bus.sout        = sout_q;
    assign bus.sout_valid  = valid_q;
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = valid_q;

endmodule
